sparse_mult_sequencer: RTL
==========================

// Module: sparse_mult_sequencer
// PURPOSE
// - Top-level sequencer for one sparse x dense polynomial multiply over GF(2)[x]/(x^n-1).
// - Sits upstream of the sparse/dense XOR-accumulate controller, which processes one packed
//   sparse word ({pos_hi[31:16], pos_lo[15:0]}) per start/done handshake.
// - Phase 1 zeroes the accumulator memory. Phase 2 walks every sparse word through the controller.
// - Phase 3 streams the accumulator out with valid/ready, masking the unused top bits of the last word.
// PARAMETERS
// - WORD_WIDTH       32    accumulator/stream word width
// - MEM_SIZE         553   accumulator words per polynomial
// - MEM_SPARSE_SIZE  50    packed sparse words to dispatch
// - TAIL_BITS        5     valid LSBs in word MEM_SIZE-1 (n = 17669)
// - TIMEOUT          4096  max cycles from ctrl_start_o to ctrl_done_i
// PORTS
// - clk           in   1           clock
// - rst_n         in   1           async reset, active-low
// - start_i       in   1           begin a multiply; sampled only in IDLE
// - busy_o        out  1           high from accepted start until return to IDLE
// - done_o        out  1           1-cycle pulse when the last stream word is accepted
// - error_o       out  1           sticky controller timeout; cleared by the next accepted start
// - sparse_addr_o out  10          sparse memory address presented to the controller
// - ctrl_start_o  out  1           1-cycle start pulse to the controller
// - ctrl_done_i   in   1           controller process_done
// - acc_own_o     out  1           1 = sequencer drives the acc port; 0 = controller drives it
// - acc_addr_o    out  10          acc address; synchronous read, data valid 1 cycle later
// - acc_wdata_o   out  WORD_WIDTH  acc write data
// - acc_we_o      out  1           acc write enable
// - acc_rdata_i   in   WORD_WIDTH  acc read data
// - out_data_o    out  WORD_WIDTH  product word, LSW first
// - out_valid_o   out  1           out_data_o valid
// - out_ready_i   in   1           consumer accepts when valid&ready
// - out_last_o    out  1           marks word MEM_SIZE-1
// BEHAVIOUR
// - Reset: every output 0 except acc_own_o=1; state IDLE; all counters 0.
// - IDLE: start_i -> CLEAR; busy_o=1, error_o=0, word counter=0.
// - CLEAR: acc_we_o=1, acc_wdata_o=0, acc_addr_o=counter; one word per cycle.
//   - After addr MEM_SIZE-1 is written: acc_we_o=0, sparse index=0, go to DISPATCH.
// - DISPATCH: sparse_addr_o=index, acc_own_o=0, ctrl_start_o=1 for exactly one cycle
//   -> WAIT_CTRL; timer=0.
// - WAIT_CTRL: ctrl_done_i -> NEXT.
//   - Timer reaching TIMEOUT-1 -> error_o=1 and go to DRAIN_ADDR (partial result still streamed).
// - NEXT: index==MEM_SPARSE_SIZE-1 -> DRAIN_ADDR with acc_own_o=1, counter=0;
//   else index+1 -> DISPATCH.
// - DRAIN_ADDR: acc_addr_o=counter -> DRAIN_CAP.
// - DRAIN_CAP: register acc_rdata_i into out_data_o, assert out_valid_o -> DRAIN_OUT.
//   - Word MEM_SIZE-1 is ANDed with (1<<TAIL_BITS)-1 and raises out_last_o.
// - DRAIN_OUT: out_data_o/out_last_o held stable while valid&&!ready.
//   - On valid&ready: drop valid; if last -> DONE, else counter+1 -> DRAIN_ADDR.
//   - Throughput is 1 word per 3 cycles at best; this is accepted.
// - DONE: done_o=1 for one cycle, busy_o=0 -> IDLE.
// - Boundaries:
//   - start_i outside IDLE is ignored.
//   - ctrl_done_i outside WAIT_CTRL is ignored.
//   - ctrl_done_i in the same cycle as timer expiry counts as done (no error).
//   - MEM_SPARSE_SIZE==0 is illegal (elaboration check).
//   - Counters are 10 bits; MEM_SIZE <= 1024 is required.
// - Reset asserted mid-operation: immediate return to IDLE with reset values.
//   - The acc contents are undefined afterwards; the next start re-clears them.
// - acc_own_o changes only on cycles where neither side writes.
// STRUCTURE
// - Shared package: state encoding localparams, MEM_SIZE/TAIL_BITS/WORD_WIDTH defaults, TAIL_MASK constant.
// - One sub-module, seq_timeout_timer: clear, enable, expired flag.
// - Everything else is a single FSM plus counters.
// TESTING
// - 1. Reset, then start; acc model pre-filled 0xFFFFFFFF
//      -> 553 zero writes, addr 0..552, then first ctrl_start_o.
// - 2. Controller model with done after 10 cycles, MEM_SPARSE_SIZE=3
//      -> exactly 3 ctrl_start_o pulses, sparse_addr_o 0,1,2, acc_own_o=0 during each.
// - 3. Acc model preloaded with word552=0xFFFFFFFF, out_ready_i=1
//      -> 553 words out, last = 0x0000001F with out_last_o=1, then done_o pulse.
// - 4. out_ready_i randomly low 50%
//      -> no word lost/duplicated; data stable while stalled; order 0..552.
// - 5. Controller never returns done, TIMEOUT=16
//      -> error_o=1 after 16 cycles, stream still completes, done_o pulses.
//      Next start clears error_o.
// - 6. rst_n low during DISPATCH of index 1
//      -> all outputs reset; a new start restarts with a CLEAR from addr 0.

Source files
------------

// File: rtl/sparse_mult_sequencer_pkg.sv
// +---------------------------------------------------------------------------+
// | sparse_mult_sequencer_pkg : shared defaults, counter width, FSM encoding   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

package sparse_mult_sequencer_pkg;

  localparam int unsigned DEF_WORD_WIDTH      = 32;
  localparam int unsigned DEF_MEM_SIZE        = 553;
  localparam int unsigned DEF_MEM_SPARSE_SIZE = 50;
  localparam int unsigned DEF_TAIL_BITS       = 5;
  localparam int unsigned DEF_TIMEOUT         = 4096;

  // Address/index counters are fixed at 10 bits, so MEM_SIZE tops out at 1024.
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned CNT_MAX    = 1 << CNT_W;

  localparam logic [DEF_WORD_WIDTH-1:0] DEF_TAIL_MASK =
    DEF_WORD_WIDTH'((64'd1 << DEF_TAIL_BITS) - 64'd1);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CLEAR      = 4'd1,
    ST_DISPATCH   = 4'd2,
    ST_WAIT_CTRL  = 4'd3,
    ST_NEXT       = 4'd4,
    ST_DRAIN_ADDR = 4'd5,
    ST_DRAIN_CAP  = 4'd6,
    ST_DRAIN_OUT  = 4'd7,
    ST_DONE       = 4'd8
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/sparse_mult_sequencer_timer.sv
// +---------------------------------------------------------------------------+
// | seq_timeout_timer : saturating cycle counter flagging TIMEOUT-1 reached    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module seq_timeout_timer
  import sparse_mult_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned          CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]        LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired_o = (count_q == LIMIT);

  // Holds at LIMIT so expiry stays visible until the next clear.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sparse_mult_sequencer.sv
// +---------------------------------------------------------------------------+
// | sparse_mult_sequencer : clear acc, dispatch sparse words, stream product   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module sparse_mult_sequencer
  import sparse_mult_sequencer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH      = DEF_WORD_WIDTH,
  parameter int unsigned MEM_SIZE        = DEF_MEM_SIZE,
  parameter int unsigned MEM_SPARSE_SIZE = DEF_MEM_SPARSE_SIZE,
  parameter int unsigned TAIL_BITS       = DEF_TAIL_BITS,
  parameter int unsigned TIMEOUT         = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [CNT_W-1:0]      sparse_addr_o,
  output logic                  ctrl_start_o,
  input  logic                  ctrl_done_i,
  output logic                  acc_own_o,
  output logic [CNT_W-1:0]      acc_addr_o,
  output logic [WORD_WIDTH-1:0] acc_wdata_o,
  output logic                  acc_we_o,
  input  logic [WORD_WIDTH-1:0] acc_rdata_i,
  output logic [WORD_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o
);

  if (MEM_SPARSE_SIZE == 0) begin : g_chk_sparse_zero
    $error("MEM_SPARSE_SIZE must be nonzero");
  end
  if (MEM_SPARSE_SIZE > CNT_MAX) begin : g_chk_sparse_range
    $error("MEM_SPARSE_SIZE exceeds the sparse index range");
  end
  if (MEM_SIZE == 0 || MEM_SIZE > CNT_MAX) begin : g_chk_mem_size
    $error("MEM_SIZE must be within 1..1024");
  end
  if (TAIL_BITS == 0 || TAIL_BITS > WORD_WIDTH) begin : g_chk_tail
    $error("TAIL_BITS must be within 1..WORD_WIDTH");
  end
  if (TIMEOUT < 2) begin : g_chk_timeout
    $error("TIMEOUT must be at least 2");
  end

  localparam logic [CNT_W-1:0]      LAST_WORD   = CNT_W'(MEM_SIZE - 1);
  localparam logic [CNT_W-1:0]      LAST_SPARSE = CNT_W'(MEM_SPARSE_SIZE - 1);
  localparam logic [WORD_WIDTH-1:0] TAIL_MASK   = {WORD_WIDTH{1'b1}} >> (WORD_WIDTH - TAIL_BITS);

  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]        sparse_idx_q, sparse_idx_d;
  logic                    error_q, error_d;
  logic [WORD_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;

  logic                    timer_clear;
  logic                    timer_en;
  logic                    timer_expired;

  seq_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  assign sparse_addr_o = sparse_idx_q;
  assign acc_addr_o    = word_cnt_q;
  assign acc_wdata_o   = '0;
  assign error_o       = error_q;
  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;
  assign out_last_o    = out_last_q;

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    sparse_idx_d = sparse_idx_q;
    error_d      = error_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    ctrl_start_o = 1'b0;
    acc_own_o    = 1'b1;
    acc_we_o     = 1'b0;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          error_d      = 1'b0;
          word_cnt_d   = '0;
          sparse_idx_d = '0;
          state_d      = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        acc_we_o = 1'b1;
        if (word_cnt_q == LAST_WORD) begin
          word_cnt_d   = '0;
          sparse_idx_d = '0;
          state_d      = ST_DISPATCH;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end

      // The controller owns the acc port from here until NEXT; no sequencer writes.
      ST_DISPATCH: begin
        acc_own_o    = 1'b0;
        ctrl_start_o = 1'b1;
        timer_clear  = 1'b1;
        state_d      = ST_WAIT_CTRL;
      end

      // A done arriving on the expiry cycle still wins over the timeout.
      ST_WAIT_CTRL: begin
        acc_own_o = 1'b0;
        timer_en  = 1'b1;
        if (ctrl_done_i) begin
          state_d = ST_NEXT;
        end else if (timer_expired) begin
          error_d    = 1'b1;
          word_cnt_d = '0;
          state_d    = ST_DRAIN_ADDR;
        end
      end

      ST_NEXT: begin
        acc_own_o = 1'b0;
        if (sparse_idx_q == LAST_SPARSE) begin
          word_cnt_d = '0;
          state_d    = ST_DRAIN_ADDR;
        end else begin
          sparse_idx_d = sparse_idx_q + 1'b1;
          state_d      = ST_DISPATCH;
        end
      end

      ST_DRAIN_ADDR: begin
        state_d = ST_DRAIN_CAP;
      end

      ST_DRAIN_CAP: begin
        out_valid_d = 1'b1;
        if (word_cnt_q == LAST_WORD) begin
          out_data_d = acc_rdata_i & TAIL_MASK;
          out_last_d = 1'b1;
        end else begin
          out_data_d = acc_rdata_i;
          out_last_d = 1'b0;
        end
        state_d = ST_DRAIN_OUT;
      end

      ST_DRAIN_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = ST_DONE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = ST_DRAIN_ADDR;
          end
        end
      end

      ST_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        busy_o  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      sparse_idx_q <= '0;
      error_q      <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      sparse_idx_q <= sparse_idx_d;
      error_q      <= error_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end

endmodule

`default_nettype wire
